// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided square wave, per-period tick and live count.
// Optional period counter output is enabled by defining CLKDIV_PERIOD_COUNT_EN.
module clock_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 512
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             EN_IN,
    input  logic             SYNC_IN,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_LOAD_IN,
    output logic             CLK_OUT,
    output logic             TICK_OUT,
    output logic [WIDTH-1:0] COUNT_OUT,
`ifdef CLKDIV_PERIOD_COUNT_EN
    output logic [WIDTH-1:0] PERIOD_CNT_OUT,
`endif
    output logic             DIV_BUSY_OUT
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO     = {{(WIDTH-2){1'b0}}, 2'b10};

    // Divisors below 2 have no meaningful square wave, so they are raised to 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v < TWO) begin
            r = TWO;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // ceil(d/2) without a WIDTH+1 intermediate, so d = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH-1:0] half_up(input logic [WIDTH-1:0] d);
        return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
    endfunction

    logic [WIDTH-1:0] count_r, div_r, pend_r;
    logic             busy_r, clk_r, tick_r;
    logic [WIDTH-1:0] count_nxt_s, div_nxt_s, pend_nxt_s, pend_in_s;
    logic             busy_nxt_s, clk_nxt_s, tick_nxt_s, wrap_s;

    // Next-state logic; a load in the same cycle as a wrap or sync is applied immediately.
    always_comb begin
        pend_in_s   = DIV_LOAD_IN ? clamp_div(DIV_IN) : pend_r;
        wrap_s      = (count_r == (div_r - ONE));
        count_nxt_s = count_r;
        div_nxt_s   = div_r;
        pend_nxt_s  = pend_in_s;
        busy_nxt_s  = busy_r | DIV_LOAD_IN;
        clk_nxt_s   = clk_r;
        tick_nxt_s  = 1'b0;
        if (SYNC_IN) begin
            count_nxt_s = ZERO;
            div_nxt_s   = pend_in_s;
            busy_nxt_s  = 1'b0;
            clk_nxt_s   = 1'b0;
        end else if (EN_IN) begin
            if (wrap_s) begin
                count_nxt_s = ZERO;
                div_nxt_s   = pend_in_s;
                busy_nxt_s  = 1'b0;
                clk_nxt_s   = 1'b0;
                tick_nxt_s  = 1'b1;
            end else begin
                count_nxt_s = count_r + ONE;
                clk_nxt_s   = ((count_r + ONE) >= half_up(div_r));
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            count_r <= ZERO;
            div_r   <= DEF_DIV;
            pend_r  <= DEF_DIV;
            busy_r  <= 1'b0;
            clk_r   <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            div_r   <= div_nxt_s;
            pend_r  <= pend_nxt_s;
            busy_r  <= busy_nxt_s;
            clk_r   <= clk_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign CLK_OUT      = clk_r;
    assign TICK_OUT     = tick_r;
    assign COUNT_OUT    = count_r;
    assign DIV_BUSY_OUT = busy_r;

`ifdef CLKDIV_PERIOD_COUNT_EN
    logic [WIDTH-1:0] pcnt_r;

    // Elapsed-period counter, advancing together with each tick.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            pcnt_r <= ZERO;
        end else if (SYNC_IN) begin
            pcnt_r <= ZERO;
        end else if (tick_nxt_s) begin
            pcnt_r <= pcnt_r + ONE;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    assign PERIOD_CNT_OUT = pcnt_r;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: stimulus pushes expected outputs, a monitor pops and compares.
module tb_clock_divider_prog;
    localparam int W   = 16;
    localparam int DEF = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1, en = 1'b0, sync = 1'b0, load = 1'b0;
    logic [W-1:0]  div_in = '0;
    logic          clk_out, tick_out, busy_out;
    logic [W-1:0]  count_out;
`ifdef CLKDIV_PERIOD_COUNT_EN
    logic [W-1:0]  pcnt_out;
`endif

    clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .CLK_IN(clk), .RST_IN(rst), .EN_IN(en), .SYNC_IN(sync),
        .DIV_IN(div_in), .DIV_LOAD_IN(load),
        .CLK_OUT(clk_out), .TICK_OUT(tick_out), .COUNT_OUT(count_out),
`ifdef CLKDIV_PERIOD_COUNT_EN
        .PERIOD_CNT_OUT(pcnt_out),
`endif
        .DIV_BUSY_OUT(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt; int clk; int tick; int busy; int pcnt;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0;
    bit started = 0, done = 0;

    // Reference model: position within the period, active and pending divisor.
    int m_cnt, m_d, m_pend, m_busy, m_tick, m_pcnt;

    function automatic int clampi(int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, predict the result of the next rising edge.
    task automatic cyc(input bit r, input bit e, input bit s, input bit l, input int d);
        int pin;
        exp_t x;
        @(negedge clk);
        rst = r; en = e; sync = s; load = l; div_in = W'(d);
        pin = l ? clampi(d) : m_pend;
        m_tick = 0;
        if (r) begin
            m_cnt = 0; m_d = DEF; m_pend = DEF; m_busy = 0; m_pcnt = 0;
        end else if (s) begin
            m_cnt = 0; m_d = pin; m_pend = pin; m_busy = 0; m_pcnt = 0;
        end else if (e && m_cnt == m_d - 1) begin
            m_cnt = 0; m_d = pin; m_pend = pin; m_busy = 0; m_tick = 1;
            m_pcnt = (m_pcnt + 1) % 65536;
        end else begin
            if (e) m_cnt = m_cnt + 1;
            m_pend = pin;
            m_busy = (m_busy != 0 || l) ? 1 : 0;
        end
        x.cnt  = m_cnt;
        // Duty rule: high exactly when the count is in the upper floor(D/2) positions.
        x.clk  = (r || s) ? 0 : ((m_cnt >= (m_d + 1) / 2) ? 1 : 0);
        x.tick = m_tick;
        x.busy = m_busy;
        x.pcnt = m_pcnt;
        exp_q.push_back(x);
        started = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    // Count until the model says COUNT_OUT shows v, with a bounded budget.
    task automatic run_until(input int v);
        int k;
        k = 0;
        while (m_cnt != v && k < 70000) begin
            cyc(0, 1, 0, 0, 0);
            k++;
        end
        check("run_until_reach", m_cnt == v ? v : -1, v);
    endtask

    // Monitor: one expectation is due after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("count", int'(count_out), x.cnt);
                check("clk_out", int'(clk_out), x.clk);
                check("tick", int'(tick_out), x.tick);
                check("busy", int'(busy_out), x.busy);
`ifdef CLKDIV_PERIOD_COUNT_EN
                check("period_cnt", int'(pcnt_out), x.pcnt);
`endif
            end else if (started && !done) begin
                check("scoreboard_underflow", 0, 1);
            end
        end
    end

    initial begin
        int ticks, first_tick, r_en, r_sync, r_load, r_rst, r_div;
        m_cnt = 0; m_d = DEF; m_pend = DEF; m_busy = 0; m_tick = 0; m_pcnt = 0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        // Default divisor: first tick lands exactly DEF cycles after reset release.
        ticks = 0; first_tick = -1;
        for (int i = 1; i <= 1100; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (m_tick != 0) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        check("first_tick_latency", first_tick, 512);
        check("ticks_in_1100", ticks, 2);

        // Load 5 mid-period; busy until the 512 wrap, then 5-cycle periods.
        run_until(100);
        cyc(0, 1, 0, 1, 5);
        run(450);
        check("model_div5", m_d, 5);

        // Divisors 0 and 1 clamp to 2.
        cyc(0, 1, 0, 1, 0);
        run(20);
        cyc(0, 1, 0, 1, 1);
        run(20);

        // D=8 with enable dropped at count 3.
        cyc(0, 1, 0, 1, 8);
        run(20);
        run_until(3);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        run(10);

        // Load plus sync in the same cycle at count 6.
        run_until(6);
        cyc(0, 1, 1, 1, 4);
        run(12);

        // Load on the wrap cycle, then reset mid-period.
        cyc(0, 1, 0, 1, 8);
        run(20);
        run_until(7);
        cyc(0, 1, 0, 1, 20);
        run(8);
        cyc(1, 1, 0, 0, 0);
        run(5);

        // Largest divisor, applied via sync, over a full period plus its wrap.
        cyc(0, 1, 1, 1, 65535);
        run(65540);

        // Randomised traffic with small divisors.
        cyc(0, 1, 1, 1, 3);
        for (int i = 0; i < 3000; i++) begin
            r_en   = ($urandom % 8) != 0;
            r_sync = ($urandom % 97) == 0;
            r_load = ($urandom % 23) == 0;
            r_rst  = ($urandom % 600) == 0;
            r_div  = $urandom % 14;
            cyc(r_rst[0], r_en[0], r_sync[0], r_load[0], r_div);
        end

        @(posedge clk);
        #2;
        done = 1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable, parametrised clock divider. Successor to the fixed divide-by-512 T-flip-flop chain.
- Produces three outputs from one counter: a divided square wave (CLK_OUT), a one-cycle enable pulse per period (TICK_OUT), and the live count.
- Sits between the board clock and slow consumers: CPU single-step clocking, PONG frame/ball timing, display refresh.
- Divisor reloads are glitch-free: they take effect only at a period boundary or on an explicit phase restart.

Parameters:
- WIDTH, 16, width of the counter and divisor.
- DEFAULT_DIV, 512, divisor in force after reset. Must be 2..2^WIDTH-1.

Ports:
- CLK_IN  input  1  system clock; all logic on the rising edge.
- RST_IN  input  1  synchronous, active-high reset.
- EN_IN  input  1  count enable.
- SYNC_IN  input  1  synchronous phase restart.
- DIV_IN  input  WIDTH  requested divisor.
- DIV_LOAD_IN  input  1  one-cycle strobe that captures DIV_IN.
- CLK_OUT  output  1  registered divided clock.
- TICK_OUT  output  1  registered one-cycle pulse, once per period.
- COUNT_OUT  output  WIDTH  current counter value.
- DIV_BUSY_OUT  output  1  high while a loaded divisor waits to be applied.

Behaviour:
- D denotes the active divisor. Any captured DIV_IN < 2 is clamped to 2. Counter arithmetic is unsigned modulo D.
- Reset (RST_IN=1 at the clock edge; takes priority over everything):
  - counter = 0, D = DEFAULT_DIV, pending register = DEFAULT_DIV.
  - CLK_OUT = 0, TICK_OUT = 0, DIV_BUSY_OUT = 0.
  - Reset mid-period discards any pending divisor.
- Counting (EN_IN=1, SYNC_IN=0):
  - COUNT_OUT increments by 1 each cycle.
  - When COUNT_OUT == D-1 ("wrap"), the next value is 0.
- CLK_OUT duty:
  - CLK_OUT is 1 in exactly the cycles where COUNT_OUT >= ceil(D/2); otherwise 0.
  - Each period is therefore low for ceil(D/2) cycles, then high for floor(D/2) cycles.
  - Even D gives exact 50% duty.
  - CLK_OUT is a flop computed from the next counter value. No combinational path from inputs to CLK_OUT.
- TICK_OUT:
  - High for exactly one cycle: the cycle in which COUNT_OUT returns to 0 after a wrap.
  - Never asserted by reset or by SYNC_IN.
- EN_IN=0:
  - Counter and CLK_OUT hold their values. TICK_OUT = 0.
  - Pending divisor is not applied.
  - When EN_IN returns, counting resumes from the held value.
- Divisor load:
  - DIV_LOAD_IN=1 captures DIV_IN (clamped) into the pending register and sets DIV_BUSY_OUT=1 on the next cycle.
  - A second load before application overwrites the pending value. Last write wins.
  - Pending value becomes D at the next wrap (counter goes to 0, new period uses new D). DIV_BUSY_OUT then clears.
  - Load in the same cycle as a wrap: the newly captured value is applied at that wrap. DIV_BUSY_OUT stays 0.
- SYNC_IN=1 (when EN_IN=1 or EN_IN=0):
  - Counter = 0, CLK_OUT = 0, TICK_OUT = 0.
  - Any pending divisor (including one loaded in the same cycle) becomes D. DIV_BUSY_OUT clears.
- Priority: RST_IN > SYNC_IN > EN_IN.
- Latency:
  - First TICK_OUT after reset with EN_IN held high occurs DEFAULT_DIV cycles after reset deasserts.
  - First CLK_OUT rise occurs ceil(D/2) cycles after reset deasserts.
- D = 2^WIDTH-1 must work without counter overflow.

Optional Feature:
- Macro: CLKDIV_PERIOD_COUNT_EN.
- Defined:
  - Adds output PERIOD_CNT_OUT (WIDTH bits), incremented on every TICK_OUT, wrapping modulo 2^WIDTH.
  - Cleared by RST_IN and by SYNC_IN.
  - Intended for debug display of elapsed slow-clock periods.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, EN_IN=1, no loads, 1100 cycles -> TICK_OUT at cycles 512 and 1024 after reset release. CLK_OUT low 256 cycles, then high 256, repeating.
- Load DIV_IN=5 at COUNT_OUT=100 of a 512 period -> DIV_BUSY_OUT=1 until the wrap. Subsequent periods are 5 cycles: CLK_OUT low 3, high 2. TICK_OUT every 5 cycles.
- Load 0 and, separately, 1 -> both behave as D=2: CLK_OUT toggles every cycle, TICK_OUT every 2 cycles.
- D=8, drop EN_IN for 10 cycles at COUNT_OUT=3 -> COUNT_OUT holds 3, CLK_OUT holds 0, TICK_OUT=0. Resumes at 4 when EN_IN rises.
- D=8, load 4 and assert SYNC_IN in the same cycle at COUNT_OUT=6 -> next COUNT_OUT=0, no TICK_OUT, D=4 immediately, DIV_BUSY_OUT=0.
- Load 20 at COUNT_OUT=7 with D=8 (wrap cycle), then assert RST_IN mid-period -> the 20 is applied at that wrap. Reset returns D=512, COUNT_OUT=0, all outputs 0.
